// File: rtl/uart_monitor_ctl.sv
// uart_monitor_ctl: monitor-protocol sequencer (header echo, load/dump/exec); MON_TIMEOUT_EN adds the inter-byte timeout.
module uart_monitor_ctl #(parameter int unsigned TIMEOUT_CYCLES = 12000000) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        exec_pulse,
  output logic [15:0] exec_addr,
  output logic [3:0]  state_dbg,
  output logic        overrun,
  output logic        timeout_err,
  output logic        busy
);
  typedef enum logic [3:0] {
    S_ADDR_HI   = 4'd0,
    S_ADDR_LO   = 4'd1,
    S_CMD       = 4'd2,
    S_DECODE    = 4'd3,
    S_LOAD_WAIT = 4'd4,
    S_LOAD_WR   = 4'd5,
    S_DUMP_RD   = 4'd6,
    S_DUMP_CAP  = 4'd7,
    S_EXEC      = 4'd8,
    S_TX_GUARD  = 4'd9,
    S_TX_WAIT   = 4'd10
  } state_t;

  state_t state_q, state_d, ret_q, ret_d;
  logic [7:0]  rx_hold_q, data_q, data_d, tx_byte_q, tx_byte_d;
  logic [15:0] addr_q, addr_d, exec_addr_q, exec_addr_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rx_pend_q, overrun_q, transmit_q, transmit_d;
  logic        consume, can_take, tmo_hit;

  assign can_take = rx_pend_q && !is_transmitting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ADDR_HI;
      ret_q       <= S_ADDR_HI;
      rx_hold_q   <= 8'd0;
      rx_pend_q   <= 1'b0;
      overrun_q   <= 1'b0;
      data_q      <= 8'd0;
      tx_byte_q   <= 8'd0;
      transmit_q  <= 1'b0;
      addr_q      <= 16'd0;
      exec_addr_q <= 16'd0;
      op_q        <= 2'd0;
      cnt_q       <= 6'd0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      rx_hold_q   <= received ? rx_byte : rx_hold_q;
      rx_pend_q   <= received | (rx_pend_q & ~consume);
      overrun_q   <= overrun_q | (received & rx_pend_q & ~consume);
      data_q      <= data_d;
      tx_byte_q   <= tx_byte_d;
      transmit_q  <= transmit_d;
      addr_q      <= addr_d;
      exec_addr_q <= exec_addr_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    data_d      = data_q;
    tx_byte_d   = tx_byte_q;
    transmit_d  = 1'b0;
    addr_d      = addr_q;
    exec_addr_d = exec_addr_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    consume     = 1'b0;
    case (state_q)
      S_ADDR_HI, S_ADDR_LO, S_CMD: if (can_take) begin
        consume    = 1'b1;
        tx_byte_d  = rx_hold_q;
        transmit_d = 1'b1;
        state_d    = S_TX_GUARD;
        addr_d     = state_q == S_ADDR_HI ? {rx_hold_q, addr_q[7:0]} :
                     state_q == S_ADDR_LO ? {addr_q[15:8], rx_hold_q} : addr_q;
        op_d       = state_q == S_CMD ? rx_hold_q[7:6] : op_q;
        cnt_d      = state_q == S_CMD ? rx_hold_q[5:0] : cnt_q;
        ret_d      = state_q == S_ADDR_HI ? S_ADDR_LO : state_q == S_ADDR_LO ? S_CMD : S_DECODE;
      end
      S_DECODE: begin
        state_d     = op_q == 2'b00 ? S_TX_GUARD : op_q == 2'b11 ? S_EXEC :
                      cnt_q == 6'd0 ? S_ADDR_HI : op_q == 2'b01 ? S_LOAD_WAIT : S_DUMP_RD;
        transmit_d  = op_q == 2'b00;
        tx_byte_d   = op_q == 2'b00 ? 8'h3F : tx_byte_q;
        ret_d       = S_ADDR_HI;
        exec_addr_d = op_q == 2'b11 ? addr_q : exec_addr_q;
      end
      S_LOAD_WAIT: if (can_take) begin
        consume = 1'b1;
        data_d  = rx_hold_q;
        state_d = S_LOAD_WR;
      end
      S_LOAD_WR, S_DUMP_CAP: begin
        tx_byte_d  = state_q == S_LOAD_WR ? data_q : mem_rdata;
        transmit_d = 1'b1;
        addr_d     = addr_q + 16'd1;
        cnt_d      = cnt_q - 6'd1;
        ret_d      = cnt_q == 6'd1 ? S_ADDR_HI : state_q == S_LOAD_WR ? S_LOAD_WAIT : S_DUMP_RD;
        state_d    = S_TX_GUARD;
      end
      S_DUMP_RD: state_d = S_DUMP_CAP;
      S_EXEC: begin
        tx_byte_d  = 8'h21;
        transmit_d = 1'b1;
        ret_d      = S_ADDR_HI;
        state_d    = S_TX_GUARD;
      end
      S_TX_GUARD: state_d = S_TX_WAIT;
      S_TX_WAIT: state_d = is_transmitting ? S_TX_WAIT : ret_q;
      default: state_d = S_ADDR_HI;
    endcase
    if (tmo_hit) begin
      tx_byte_d  = 8'h54;
      transmit_d = 1'b1;
      ret_d      = S_ADDR_HI;
      state_d    = S_TX_GUARD;
    end
  end

`ifdef MON_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] tmo_q;
  logic        tmo_run, timeout_q;
  assign tmo_run = (state_q == S_ADDR_LO || state_q == S_CMD || state_q == S_LOAD_WAIT) && !rx_pend_q;
  assign tmo_hit = tmo_run && tmo_q == TMO_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= 24'd0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_run && !tmo_hit ? tmo_q + 24'd1 : 24'd0;
      timeout_q <= timeout_q | tmo_hit;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign transmit   = transmit_q;
  assign tx_byte    = tx_byte_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign mem_we     = state_q == S_LOAD_WR;
  assign mem_re     = state_q == S_DUMP_RD;
  assign exec_pulse = state_q == S_EXEC;
  assign exec_addr  = exec_addr_q;
  assign state_dbg  = state_q;
  assign overrun    = overrun_q;
  assign busy       = state_q != S_ADDR_HI;
endmodule

// File: tb/tb_uart_monitor_ctl.sv
// tb_uart_monitor_ctl: uart/memory models plus a frame-level reference model for uart_monitor_ctl.
module tb_uart_monitor_ctl;
  logic clk = 1'b0, rst_n = 1'b0, received = 1'b0, is_transmitting = 1'b0;
  logic [7:0] rx_byte = 8'd0, mem_rdata = 8'd0;
  logic transmit, mem_we, mem_re, exec_pulse, overrun, timeout_err, busy;
  logic [7:0] tx_byte, mem_wdata;
  logic [15:0] mem_addr, exec_addr;
  logic [3:0] state_dbg;

  int checks = 0, failures = 0;
  int cyc = 0, rcv_cyc = 0, last_tx_cyc = -1;
  int busy_left = 0, re_cnt = 0, exec_cnt = 0, spacing_err = 0;
  bit force_busy = 0, prev_tx = 0, re_pend = 0;
  logic [15:0] re_addr = 16'd0, exec_seen = 16'd0;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] tx_log [$];
  logic [23:0] wr_log [$];
  logic [7:0] none [$];
  logic [7:0] dq [$];

  uart_monitor_ctl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .exec_pulse(exec_pulse), .exec_addr(exec_addr),
    .state_dbg(state_dbg), .overrun(overrun), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (transmit) begin
      tx_log.push_back(tx_byte);
      last_tx_cyc = cyc;
      if (is_transmitting || prev_tx) spacing_err++;
    end
    prev_tx = transmit;
    if (busy_left > 0) busy_left--;
    if (transmit) busy_left = $urandom_range(5, 2);
    is_transmitting = force_busy || busy_left > 0;
    if (re_pend) mem_rdata = mem[re_addr];
    re_pend = mem_re;
    re_addr = mem_addr;
    if (mem_re) re_cnt++;
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (exec_pulse) begin
      exec_cnt++;
      exec_seen = exec_addr;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    received = 1'b1;
    rx_byte = b;
    rcv_cyc = cyc;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    repeat ($urandom_range(12, 10)) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || is_transmitting) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(n < 3000), 64'd1);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    wr_log.delete();
    re_cnt = 0;
    exec_cnt = 0;
  endtask

  task automatic compare(input logic [7:0] exp_tx[$], input logic [23:0] exp_wr[$], input int exp_re, input int exp_exec);
    chk("tx_count", tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) chk($sformatf("tx[%0d]", i), tx_log[i], exp_tx[i]);
    chk("wr_count", wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) chk($sformatf("wr[%0d]", i), wr_log[i], exp_wr[i]);
    chk("re_count", re_cnt, exp_re);
    chk("exec_count", exec_cnt, exp_exec);
    chk("state_idle", state_dbg, 4'd0);
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [7:0] cmd, input logic [7:0] fixd[$]);
    logic [7:0] exp_tx [$];
    logic [23:0] exp_wr [$];
    logic [7:0] d;
    logic [15:0] wa;
    int n, exp_re, exp_exec;
    n = int'(cmd[5:0]);
    exp_re = 0;
    exp_exec = 0;
    clear_logs();
    exp_tx = {a[15:8], a[7:0], cmd};
    send(a[15:8]);
    chk("echo_latency", 64'(last_tx_cyc - rcv_cyc), 64'd2);
    send(a[7:0]);
    send(cmd);
    if (cmd[7:6] == 2'b00) exp_tx.push_back(8'h3F);
    else if (cmd[7:6] == 2'b11) begin
      exp_tx.push_back(8'h21);
      exp_exec = 1;
    end else if (cmd[7:6] == 2'b01) begin
      for (int i = 0; i < n; i++) begin
        d = i < fixd.size() ? fixd[i] : 8'($urandom);
        wa = 16'(int'(a) + i);
        exp_tx.push_back(d);
        exp_wr.push_back({wa, d});
        ref_mem[wa] = d;
        send(d);
      end
    end else begin
      for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[16'(int'(a) + i)]);
      exp_re = n;
    end
    wait_idle();
    compare(exp_tx, exp_wr, exp_re, exp_exec);
    if (exp_exec == 1) chk("exec_addr", exec_seen, a);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] ex_tx [$];
    logic [23:0] ex_wr [$];
    logic [1:0] op;
    logic [5:0] n;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {transmit, tx_byte, mem_addr, mem_wdata, mem_we, mem_re, exec_pulse,
                          exec_addr, state_dbg, overrun, timeout_err, busy}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    dq = {8'hAA, 8'hBB, 8'hCC};
    run_frame(16'h1234, 8'h43, dq);
    run_frame(16'h1234, 8'h82, none);
    run_frame(16'hFFFF, 8'h42, none);
    run_frame(16'hC000, 8'hC0, none);
    run_frame(16'h0000, 8'h05, none);
    run_frame(16'h4321, 8'h40, none);
    run_frame(16'h4321, 8'h80, none);

    chk("overrun_clear", overrun, 1'b0);
    clear_logs();
    force_busy = 1;
    repeat (2) @(negedge clk);
    pulse(8'h55);
    pulse(8'h12);
    repeat (3) @(negedge clk);
    chk("overrun_set", overrun, 1'b1);
    chk("held_while_busy", state_dbg, 4'd0);
    force_busy = 0;
    repeat (12) @(negedge clk);
    send(8'h34);
    send(8'h00);
    wait_idle();
    ex_tx = {8'h12, 8'h34, 8'h00, 8'h3F};
    ex_wr.delete();
    compare(ex_tx, ex_wr, 0, 0);

    send(8'h12);
    send(8'h34);
    chk("midframe_state", state_dbg, 4'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset", {transmit, tx_byte, mem_addr, mem_wdata, mem_we, mem_re, exec_pulse,
                           exec_addr, state_dbg, overrun, timeout_err, busy}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run_frame(16'hC0DE, 8'hC0, none);

    for (int k = 0; k < 20; k++) begin
      op = 2'($urandom);
      n = 6'($urandom_range(6, 0));
      a = $urandom_range(3, 0) == 0 ? 16'hFFFF - 16'($urandom_range(3, 0)) : 16'($urandom);
      run_frame(a, {op, n}, none);
    end
    chk("tx_spacing", spacing_err, 0);

`ifdef MON_TIMEOUT_EN
    clear_logs();
    send(8'h77);
    begin
      int t0, w;
      t0 = rcv_cyc;
      w = 0;
      while (!timeout_err && w < 400) begin
        @(negedge clk);
        w++;
      end
      chk("timeout_window", 64'((cyc - t0) >= 100 && (cyc - t0) <= 115), 64'd1);
    end
    wait_idle();
    ex_tx = {8'h77, 8'h54};
    ex_wr.delete();
    compare(ex_tx, ex_wr, 0, 0);
`else
    chk("timeout_err_tied", timeout_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
